alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 159 +++++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential wrapper around an external combinational ALU: decodes the ALU control code,
// registers the operands, captures one result per request and hands it out via ready/valid.
module alu_seq #(
    parameter int unsigned REGSIZE = 64
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_aluop,
    input  logic [2:0]         req_funct3,
    input  logic               req_funct7b5,
    input  logic [REGSIZE-1:0] req_a,
    input  logic [REGSIZE-1:0] req_b,

    output logic [REGSIZE-1:0] alu_in1,
    output logic [REGSIZE-1:0] alu_in2,
    output logic [3:0]         alu_ctl,
    input  logic [REGSIZE-1:0] alu_result,
    input  logic               alu_zero,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [REGSIZE-1:0] rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [15:0]        op_count
);

    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlSub = 4'b0110;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    state_t               state_q;
    logic [REGSIZE-1:0]   in1_q;
    logic [REGSIZE-1:0]   in2_q;
    logic [3:0]           ctl_q;
    logic [REGSIZE-1:0]   result_q;
    logic                 zero_q;
    logic                 err_q;
    logic [15:0]          count_q;

    logic [3:0]           dec_ctl;
    logic                 dec_legal;

    // Control decode; anything not listed (including aluop 11) is flagged illegal.
    always_comb begin
        dec_ctl   = CtlAnd;
        dec_legal = 1'b0;
        unique case (req_aluop)
            2'b00: begin
                dec_ctl   = CtlAdd;
                dec_legal = 1'b1;
            end
            2'b01: begin
                dec_ctl   = CtlSub;
                dec_legal = 1'b1;
            end
            2'b10: begin
                case ({req_funct3, req_funct7b5})
                    4'b0000: begin
                        dec_ctl   = CtlAdd;
                        dec_legal = 1'b1;
                    end
                    4'b0001: begin
                        dec_ctl   = CtlSub;
                        dec_legal = 1'b1;
                    end
                    4'b1110: begin
                        dec_ctl   = CtlAnd;
                        dec_legal = 1'b1;
                    end
                    4'b1100: begin
                        dec_ctl   = CtlOr;
                        dec_legal = 1'b1;
                    end
                    default: begin
                        dec_ctl   = CtlAnd;
                        dec_legal = 1'b0;
                    end
                endcase
            end
            2'b11: begin
                dec_ctl   = CtlAnd;
                dec_legal = 1'b0;
            end
            default: begin
                dec_ctl   = CtlAnd;
                dec_legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            in1_q    <= '0;
            in2_q    <= '0;
            ctl_q    <= CtlAnd;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (dec_legal) begin
                            in1_q   <= req_a;
                            in2_q   <= req_b;
                            ctl_q   <= dec_ctl;
                            state_q <= StExec;
                        end else begin
                            // Illegal requests skip the ALU and leave its operands untouched.
                            result_q <= '0;
                            zero_q   <= 1'b0;
                            err_q    <= 1'b1;
                            state_q  <= StResp;
                        end
                    end
                end
                StExec: begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                    err_q    <= 1'b0;
                    state_q  <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        count_q <= count_q + 16'd1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_ctl    = ctl_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a small behavioural ALU attached to the ALU ports.
module tb_alu_seq;

    localparam int unsigned REGSIZE = 64;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_aluop;
    logic [2:0]         req_funct3;
    logic               req_funct7b5;
    logic [REGSIZE-1:0] req_a;
    logic [REGSIZE-1:0] req_b;
    logic [REGSIZE-1:0] alu_in1;
    logic [REGSIZE-1:0] alu_in2;
    logic [3:0]         alu_ctl;
    logic [REGSIZE-1:0] alu_result;
    logic               alu_zero;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [REGSIZE-1:0] rsp_result;
    logic               rsp_zero;
    logic               rsp_err;
    logic [15:0]        op_count;

    int checks;
    int failures;

    alu_seq #(
        .REGSIZE(REGSIZE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_aluop   (req_aluop),
        .req_funct3  (req_funct3),
        .req_funct7b5(req_funct7b5),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_ctl     (alu_ctl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0110: alu_result = alu_in1 - alu_in2;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        req_valid    = 1'b1;
        req_aluop    = op;
        req_funct3   = f3;
        req_funct7b5 = f7;
        req_a        = a;
        req_b        = b;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic [63:0] res, input logic zero,
                             input logic err);
        check_eq({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        check_eq({tag, ".result"}, rsp_result, res);
        check_eq({tag, ".zero"}, 64'(rsp_zero), 64'(zero));
        check_eq({tag, ".err"}, 64'(rsp_err), 64'(err));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, ".rsp_result"}, rsp_result, 64'd0);
        check_eq({tag, ".rsp_zero"}, 64'(rsp_zero), 64'd0);
        check_eq({tag, ".rsp_err"}, 64'(rsp_err), 64'd0);
        check_eq({tag, ".alu_in1"}, alu_in1, 64'd0);
        check_eq({tag, ".alu_in2"}, alu_in2, 64'd0);
        check_eq({tag, ".alu_ctl"}, 64'(alu_ctl), 64'd0);
        check_eq({tag, ".op_count"}, 64'(op_count), 64'd0);
    endtask

    // Legal op with rsp_ready=1: EXEC after accept, RESP after the next edge, IDLE after the next.
    task automatic legal_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                            input logic f7, input logic [63:0] a, input logic [63:0] b,
                            input logic [3:0] ctl, input logic [63:0] res, input logic zero,
                            input logic [15:0] cnt);
        issue(op, f3, f7, a, b);
        check_eq({tag, ".exec_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, ".exec_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, ".ctl"}, 64'(alu_ctl), 64'(ctl));
        @(negedge clk);
        check_rsp(tag, res, zero, 1'b0);
        @(negedge clk);
        check_eq({tag, ".done_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, ".done_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, ".count"}, 64'(op_count), 64'(cnt));
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_aluop    = 2'b00;
        req_funct3   = 3'b000;
        req_funct7b5 = 1'b0;
        req_a        = '0;
        req_b        = '0;
        rsp_ready    = 1'b1;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        legal_op("add", 2'b10, 3'b000, 1'b0, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 16'd1);
        legal_op("beq", 2'b01, 3'b000, 1'b0, 64'h1234, 64'h1234, 4'b0110, 64'd0, 1'b1, 16'd2);
        legal_op("and", 2'b10, 3'b111, 1'b0, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0,
                 16'd3);
        legal_op("or", 2'b10, 3'b110, 1'b0, 64'hF0F0, 64'hFF00, 4'b0001, 64'hFFF0, 1'b0, 16'd4);
        legal_op("sub", 2'b10, 3'b000, 1'b1, 64'd10, 64'd3, 4'b0110, 64'd7, 1'b0, 16'd5);
        legal_op("ld", 2'b00, 3'b011, 1'b0, 64'h100, 64'h8, 4'b0010, 64'h108, 1'b0, 16'd6);

        // Illegal: response right after the accept edge, ALU registers keep the last legal op.
        issue(2'b11, 3'b000, 1'b0, 64'hAA, 64'hBB);
        check_rsp("ill11", 64'd0, 1'b0, 1'b1);
        check_eq("ill11.in1", alu_in1, 64'h100);
        check_eq("ill11.ctl", 64'(alu_ctl), 64'b0010);
        @(negedge clk);
        check_eq("ill11.done_valid", 64'(rsp_valid), 64'd0);
        check_eq("ill11.count", 64'(op_count), 64'd7);

        issue(2'b10, 3'b111, 1'b1, 64'h1, 64'h2);
        check_rsp("ill_and1", 64'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("ill_and1.count", 64'(op_count), 64'd8);

        // Backpressure: response held, new requests ignored.
        rsp_ready = 1'b0;
        issue(2'b10, 3'b000, 1'b0, 64'd100, 64'd23);
        @(negedge clk);
        req_valid    = 1'b1;
        req_aluop    = 2'b10;
        req_funct3   = 3'b000;
        req_funct7b5 = 1'b0;
        req_a        = 64'd1;
        req_b        = 64'd1;
        for (int i = 0; i < 5; i++) begin
            check_rsp("stall", 64'd123, 1'b0, 1'b0);
            check_eq("stall.req_ready", 64'(req_ready), 64'd0);
            check_eq("stall.in1", alu_in1, 64'd100);
            @(negedge clk);
        end
        check_rsp("stall_end", 64'd123, 1'b0, 1'b0);
        check_eq("stall_end.count", 64'(op_count), 64'd8);
        rsp_ready = 1'b1;
        @(negedge clk);
        // No accept on the exit edge even with req_valid high.
        check_eq("exit.valid", 64'(rsp_valid), 64'd0);
        check_eq("exit.req_ready", 64'(req_ready), 64'd1);
        check_eq("exit.in1", alu_in1, 64'd100);
        check_eq("exit.count", 64'(op_count), 64'd9);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("reaccept.req_ready", 64'(req_ready), 64'd0);
        check_eq("reaccept.in1", alu_in1, 64'd1);
        @(negedge clk);
        check_rsp("reaccept", 64'd2, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("reaccept.count", 64'(op_count), 64'd10);

        // Reset while in EXEC.
        issue(2'b10, 3'b000, 1'b0, 64'd40, 64'd2);
        check_eq("rst_exec.pre", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_exec");
        repeat (2) @(negedge clk);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        legal_op("post_rst", 2'b10, 3'b000, 1'b0, 64'd40, 64'd2, 4'b0010, 64'd42, 1'b0, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
